pueo_rescale_coeff_loader: RTL and testbench
============================================

Name: pueo_rescale_coeff_loader

Overview:
- Writer-side sequencer for the rescaler coefficient interface (coeff_wr / coeff_update / coeff_dat, 18-bit Q0.19 unsigned-fraction coefficients).
- Holds a per-lane coefficient table written by control logic.
- On commit, shifts the table into the rescaler's B1 cascade chain, then issues one update strobe so every lane switches to its new coefficient on the same cycle.
- Optionally holds the update until a frame-boundary sync.

Parameters:
- NSAMP, 8, number of lanes (length of the B cascade chain).
- CBITS, 18, coefficient width.
- DEFAULT_COEFF, 17476, table reset value for all lanes (1/30 in Q0.19).
- USE_SYNC, 0, 1 = coeff_update_o waits for sync_i; 0 = issued immediately.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- lane_wr_i  in  1  table write strobe
- lane_addr_i  in  $clog2(NSAMP)  table lane index
- lane_dat_i  in  CBITS  table write data
- commit_i  in  1  start load sequence (single-cycle strobe)
- sync_i  in  1  frame-boundary strobe (used only when USE_SYNC=1)
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse: sequence complete
- coeff_wr_o  out  1  to rescaler coeff_wr_i
- coeff_update_o  out  1  to rescaler coeff_update_i
- coeff_dat_o  out  CBITS  to rescaler coeff_dat_i

Behaviour:
- All outputs are registered.
- Reset values: busy_o=0, done_o=0, coeff_wr_o=0, coeff_update_o=0, coeff_dat_o=0, FSM=IDLE, all table entries=DEFAULT_COEFF.
- Reset does not touch the rescaler, which keeps its previous coefficients.

Rescaler timing contract:
- The rescaler registers wr/update internally by one cycle.
- coeff_dat_o must be valid the cycle AFTER the matching coeff_wr_o.
- coeff_update_o must be asserted no earlier than the cycle after the last coeff_wr_o.
- Lanes are shifted in order: NSAMP-1 first, lane 0 last, so the first word shifted ends in the last DSP.

Table writes:
- lane_wr_i in IDLE: table[lane_addr_i] <= lane_dat_i.
- lane_wr_i while busy_o=1: ignored; the table is frozen during a sequence.
- lane_addr_i >= NSAMP: ignored.
- lane_wr_i and commit_i in the same IDLE cycle: the write lands first, and the commit uses the new value.

FSM states: IDLE, SHIFT, WAIT_SYNC, UPDATE.
- IDLE: commit_i=1 -> SHIFT, with shift counter k=0. busy_o rises next cycle (cycle 1, taking commit as cycle 0).
- SHIFT, cycles 1..NSAMP:
  - coeff_wr_o=1.
  - coeff_dat_o in cycle c (c=2..NSAMP+1) = table[NSAMP-(c-1)].
  - After cycle NSAMP: go to UPDATE if USE_SYNC=0, else WAIT_SYNC.
  - coeff_dat_o for the final lane (lane 0) is presented in cycle NSAMP+1.
- WAIT_SYNC:
  - coeff_wr_o=0 and coeff_dat_o held.
  - sync_i is sampled from cycle NSAMP+1 onward. The first sync_i=1 -> UPDATE next cycle.
  - sync_i pulses before cycle NSAMP+1 are not remembered.
- UPDATE:
  - coeff_update_o=1 for exactly one cycle. With USE_SYNC=0 this is cycle NSAMP+1.
  - Next cycle: done_o=1 for one cycle, busy_o=0, coeff_dat_o=0, return to IDLE.
- coeff_dat_o is 0 whenever it is not in a data phase.
- commit_i while busy_o=1 is ignored (not queued). A commit in the same cycle as done_o is accepted.
- rst asserted mid-sequence: everything returns to reset values immediately and no update is issued.
  - The rescaler B1 chain may then hold partial data, but B2, the active coefficient, is untouched.
  - A new commit fully reloads the chain.
- coeff_wr_o and coeff_update_o are never high in the same cycle.

Test Plan:
- Use NSAMP=8 and USE_SYNC=0. Include a bench model of the rescaler chain: a registered ceb1/ceb2 plus an 8-deep B1 shift and a B2 copy.
- Default load: after reset, commit with no table writes -> all 8 model B2 entries = 17476.
- Ordered load:
  - Stimulus: write lane i = 1000+i, commit at cycle 0.
  - Required: coeff_wr_o high cycles 1-8; coeff_dat_o = 1007..1000 in cycles 2-9; coeff_update_o in cycle 9; done_o in cycle 10.
  - Required: model lane i B2 = 1000+i; busy_o high cycles 1-9.
- Sync hold: USE_SYNC=1, commit, sync_i pulsed at cycle 5 and again at cycle 20.
  - Required: the cycle-5 pulse is ignored; coeff_update_o in cycle 21; done_o in cycle 22.
- Busy protection: during SHIFT, pulse commit_i and write lane 3 = 5.
  - Required: exactly 8 wr cycles and 1 update; model lane 3 keeps the pre-commit value; a later commit loads the unchanged table.
- Reset mid-shift: assert rst in cycle 4.
  - Required: all outputs 0 immediately; no coeff_update_o; model B2 values unchanged; table back to 17476.
  - Required: a post-reset commit loads 17476 into all lanes.
- Back-to-back: second commit in the done_o cycle -> second sequence starts with wr the following cycle; two updates total; final B2 = second table.

Source files
------------

// File: rtl/pueo_rescale_coeff_loader.sv
// Writer-side sequencer for the rescaler coefficient chain: holds a per-lane table,
// shifts it into the B1 cascade on commit, then issues a single update strobe.
module pueo_rescale_coeff_loader #(
  parameter int NSAMP         = 8,
  parameter int CBITS         = 18,
  parameter int DEFAULT_COEFF = 17476,
  parameter int USE_SYNC      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lane_wr_i,
  input  logic [$clog2(NSAMP)-1:0] lane_addr_i,
  input  logic [CBITS-1:0]         lane_dat_i,
  input  logic                     commit_i,
  input  logic                     sync_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     coeff_wr_o,
  output logic                     coeff_update_o,
  output logic [CBITS-1:0]         coeff_dat_o
);
  localparam int AW = $clog2(NSAMP);
  localparam logic [AW-1:0] LAST = AW'(NSAMP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_SYNC, UPDATE} state_t;

  state_t                      state, state_nx;
  logic [AW-1:0]               k, k_nx;
  logic [NSAMP-1:0][CBITS-1:0] tbl;
  logic                        addr_ok;
  logic                        busy_nx, done_nx, wr_nx, upd_nx;
  logic [CBITS-1:0]            dat_nx;

  // Power-of-two lane counts cover the whole address space, so no range check is needed.
  generate
    if (NSAMP == (1 << AW)) begin : g_full
      assign addr_ok = 1'b1;
    end else begin : g_part
      assign addr_ok = ({{(32-AW){1'b0}}, lane_addr_i} < 32'(NSAMP));
    end
  endgenerate

  // Table is frozen whenever a sequence is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tbl <= {NSAMP{CBITS'(DEFAULT_COEFF)}};
    else if (lane_wr_i && state == IDLE && addr_ok)
      tbl[lane_addr_i] <= lane_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      k              <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      coeff_dat_o    <= '0;
    end else begin
      state          <= state_nx;
      k              <= k_nx;
      busy_o         <= busy_nx;
      done_o         <= done_nx;
      coeff_wr_o     <= wr_nx;
      coeff_update_o <= upd_nx;
      coeff_dat_o    <= dat_nx;
    end
  end

  // Data trails each wr strobe by one cycle, matching the rescaler's internal register.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    wr_nx    = 1'b0;
    upd_nx   = 1'b0;
    done_nx  = 1'b0;
    dat_nx   = '0;
    case (state)
      IDLE: begin
        if (commit_i) begin
          state_nx = SHIFT;
          k_nx     = '0;
          wr_nx    = 1'b1;
        end
      end
      SHIFT: begin
        dat_nx = tbl[LAST - k];
        if (k == LAST) begin
          if (USE_SYNC != 0) begin
            state_nx = WAIT_SYNC;
          end else begin
            state_nx = UPDATE;
            upd_nx   = 1'b1;
          end
        end else begin
          k_nx  = k + 1'b1;
          wr_nx = 1'b1;
        end
      end
      WAIT_SYNC: begin
        dat_nx = coeff_dat_o;
        if (sync_i) begin
          state_nx = UPDATE;
          upd_nx   = 1'b1;
        end
      end
      UPDATE: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end
endmodule

// File: tb/tb_pueo_rescale_coeff_loader.sv
// Directed bench for pueo_rescale_coeff_loader with a model of the rescaler B1/B2 chain.
module tb_pueo_rescale_coeff_loader;
  localparam logic [17:0] DEF = 18'd17476;

  logic        clk = 1'b0, rst = 1'b1;
  logic        lane_wr = 1'b0, commit = 1'b0, commit_s = 1'b0, sync = 1'b0;
  logic [2:0]  lane_addr = '0;
  logic [17:0] lane_dat = '0;
  logic        busy, done, wr, upd;
  logic [17:0] dat;
  logic        busy_s, done_s, wr_s, upd_s;
  logic [17:0] dat_s;
  int          vecs = 0, errs = 0;

  pueo_rescale_coeff_loader #(.NSAMP(8), .CBITS(18), .DEFAULT_COEFF(17476), .USE_SYNC(0)) dut (
    .clk(clk), .rst(rst), .lane_wr_i(lane_wr), .lane_addr_i(lane_addr), .lane_dat_i(lane_dat),
    .commit_i(commit), .sync_i(sync), .busy_o(busy), .done_o(done), .coeff_wr_o(wr),
    .coeff_update_o(upd), .coeff_dat_o(dat));

  pueo_rescale_coeff_loader #(.NSAMP(8), .CBITS(18), .DEFAULT_COEFF(17476), .USE_SYNC(1)) dut_s (
    .clk(clk), .rst(rst), .lane_wr_i(lane_wr), .lane_addr_i(lane_addr), .lane_dat_i(lane_dat),
    .commit_i(commit_s), .sync_i(sync), .busy_o(busy_s), .done_o(done_s), .coeff_wr_o(wr_s),
    .coeff_update_o(upd_s), .coeff_dat_o(dat_s));

  always #5 clk = ~clk;

  // Rescaler model: registered enables, B1 shifts toward the last DSP, B2 copies on update.
  logic        ceb1 = 1'b0, ceb2 = 1'b0;
  logic [17:0] b1[8];
  logic [17:0] b2[8];
  always @(posedge clk) begin
    ceb1 <= wr;
    ceb2 <= upd;
    if (ceb1) begin
      b1[0] <= dat;
      for (int i = 1; i < 8; i++) b1[i] <= b1[i-1];
    end
    if (ceb2) for (int i = 0; i < 8; i++) b2[i] <= b1[i];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_lane(input logic [2:0] a, input logic [17:0] d);
    lane_wr = 1'b1; lane_addr = a; lane_dat = d;
    tick();
    lane_wr = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy got %b want 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset done got %b want 0", done); end
    vecs++; if (wr !== 1'b0) begin errs++; $display("FAIL reset wr got %b want 0", wr); end
    vecs++; if (upd !== 1'b0) begin errs++; $display("FAIL reset upd got %b want 0", upd); end
    vecs++; if (dat !== 18'd0) begin errs++; $display("FAIL reset dat got %0d want 0", dat); end
    rst = 1'b0;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_rel busy got %b want 0", busy); end
  endtask

  task automatic test_default_load();
    commit = 1'b1;
    for (int c = 1; c <= 12; c++) begin tick(); commit = 1'b0; end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (b2[i] !== DEF) begin errs++; $display("FAIL default b2[%0d] got %0d want %0d", i, b2[i], DEF); end
    end
  endtask

  task automatic test_ordered_load();
    logic        ew, eu, ed, eb;
    logic [17:0] edat;
    for (int i = 0; i < 8; i++) write_lane(3'(i), 18'(1000 + i));
    commit = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick(); commit = 1'b0;
      ew = (c >= 1 && c <= 8); eu = (c == 9); ed = (c == 10); eb = (c >= 1 && c <= 9);
      edat = (c >= 2 && c <= 9) ? 18'(1009 - c) : 18'd0;
      vecs++; if (wr !== ew) begin errs++; $display("FAIL ordered wr c=%0d got %b want %b", c, wr, ew); end
      vecs++; if (dat !== edat) begin errs++; $display("FAIL ordered dat c=%0d got %0d want %0d", c, dat, edat); end
      vecs++; if (upd !== eu) begin errs++; $display("FAIL ordered upd c=%0d got %b want %b", c, upd, eu); end
      vecs++; if (done !== ed) begin errs++; $display("FAIL ordered done c=%0d got %b want %b", c, done, ed); end
      vecs++; if (busy !== eb) begin errs++; $display("FAIL ordered busy c=%0d got %b want %b", c, busy, eb); end
    end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (b2[i] !== 18'(1000 + i)) begin errs++; $display("FAIL ordered b2[%0d] got %0d want %0d", i, b2[i], 1000 + i); end
    end
  endtask

  task automatic test_sync();
    logic ew, eu, ed;
    commit_s = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick(); commit_s = 1'b0;
      sync = (c == 5 || c == 20);
      ew = (c >= 1 && c <= 8); eu = (c == 21); ed = (c == 22);
      vecs++; if (wr_s !== ew) begin errs++; $display("FAIL sync wr c=%0d got %b want %b", c, wr_s, ew); end
      vecs++; if (upd_s !== eu) begin errs++; $display("FAIL sync upd c=%0d got %b want %b", c, upd_s, eu); end
      vecs++; if (done_s !== ed) begin errs++; $display("FAIL sync done c=%0d got %b want %b", c, done_s, ed); end
      if (c == 15) begin
        vecs++; if (dat_s !== DEF) begin errs++; $display("FAIL sync hold dat got %0d want %0d", dat_s, DEF); end
      end
    end
    sync = 1'b0;
  endtask

  task automatic test_busy_protect();
    int nwr = 0, nupd = 0;
    commit = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      commit = (c == 3); lane_wr = (c == 3); lane_addr = 3'd3; lane_dat = 18'd5;
      if (wr) nwr++;
      if (upd) nupd++;
      vecs++; if (wr && upd) begin errs++; $display("FAIL busy wr_upd_overlap c=%0d got 1 want 0", c); end
    end
    vecs++; if (nwr != 8) begin errs++; $display("FAIL busy wr_count got %0d want 8", nwr); end
    vecs++; if (nupd != 1) begin errs++; $display("FAIL busy upd_count got %0d want 1", nupd); end
    vecs++; if (b2[3] !== 18'd1003) begin errs++; $display("FAIL busy b2[3] got %0d want 1003", b2[3]); end
    commit = 1'b1;
    for (int c = 1; c <= 12; c++) begin tick(); commit = 1'b0; end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (b2[i] !== 18'(1000 + i)) begin errs++; $display("FAIL busy reload b2[%0d] got %0d want %0d", i, b2[i], 1000 + i); end
    end
  endtask

  task automatic test_reset_mid();
    int nupd = 0;
    commit = 1'b1;
    for (int c = 1; c <= 3; c++) begin tick(); commit = 1'b0; if (upd) nupd++; end
    tick(); rst = 1'b1; #1;
    vecs++; if ({busy, done, wr, upd} !== 4'b0) begin errs++; $display("FAIL rst_mid ctl got %b want 0000", {busy, done, wr, upd}); end
    vecs++; if (dat !== 18'd0) begin errs++; $display("FAIL rst_mid dat got %0d want 0", dat); end
    tick(); tick(); rst = 1'b0;
    for (int c = 0; c < 12; c++) begin tick(); if (upd) nupd++; end
    vecs++; if (nupd != 0) begin errs++; $display("FAIL rst_mid upd_count got %0d want 0", nupd); end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (b2[i] !== 18'(1000 + i)) begin errs++; $display("FAIL rst_mid b2[%0d] got %0d want %0d", i, b2[i], 1000 + i); end
    end
    commit = 1'b1;
    for (int c = 1; c <= 12; c++) begin tick(); commit = 1'b0; end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (b2[i] !== DEF) begin errs++; $display("FAIL rst_reload b2[%0d] got %0d want %0d", i, b2[i], DEF); end
    end
  endtask

  task automatic test_back_to_back();
    int nwr = 0, nupd = 0;
    logic [17:0] e;
    for (int i = 0; i < 8; i++) write_lane(3'(i), 18'(3000 + i));
    commit = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      // Same-cycle write and commit: the new lane 5 value must be the one loaded.
      commit = (c == 10); lane_wr = (c == 10); lane_addr = 3'd5; lane_dat = 18'd4242;
      if (wr) nwr++;
      if (upd) nupd++;
      if (c == 10) begin
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL b2b done c=10 got %b want 1", done); end
      end
      if (c == 11) begin
        vecs++; if (wr !== 1'b1) begin errs++; $display("FAIL b2b wr c=11 got %b want 1", wr); end
      end
      if (c == 14) begin
        vecs++; if (dat !== 18'd4242) begin errs++; $display("FAIL b2b dat c=14 got %0d want 4242", dat); end
      end
      if (c == 19) begin
        vecs++; if (upd !== 1'b1) begin errs++; $display("FAIL b2b upd c=19 got %b want 1", upd); end
      end
    end
    vecs++; if (nwr != 16) begin errs++; $display("FAIL b2b wr_count got %0d want 16", nwr); end
    vecs++; if (nupd != 2) begin errs++; $display("FAIL b2b upd_count got %0d want 2", nupd); end
    for (int i = 0; i < 8; i++) begin
      e = (i == 5) ? 18'd4242 : 18'(3000 + i);
      vecs++; if (b2[i] !== e) begin errs++; $display("FAIL b2b b2[%0d] got %0d want %0d", i, b2[i], e); end
    end
  endtask

  initial begin
    test_reset();
    test_default_load();
    test_sync();
    test_ordered_load();
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
